// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential fetch addresses, buffers in-order
// responses with their PCs in a small FIFO and hands {pc, inst} to decode.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        jump,
    input  logic [31:0] jump_addr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 2;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic [SW-1:0] credits_used;
    logic          resp_drop;
    logic          resp_live;
    logic          push;
    logic          pop;
    logic          fire;
    logic [CW-1:0] drop_after;
    logic [CW-1:0] infl_after;
    logic [31:0]   redirect_pc;

    // Every outstanding request, live or stale, holds a FIFO slot so a push can never overflow.
    assign credits_used = SW'(count) + SW'(inflight) + SW'(drop_cnt);
    assign req_valid    = rst && !jump && (credits_used < SW'(DEPTH));
    assign req_addr     = fetch_pc;
    assign fire         = req_valid && req_ready;

    assign resp_drop = resp_valid && (drop_cnt != '0);
    assign resp_live = resp_valid && (drop_cnt == '0);
    assign push      = resp_live && !jump;

    assign out_valid = (count != '0) && !jump;
    assign pop       = out_valid && out_ready;
    assign out_pc    = (count != '0) ? pc_mem[rd_ptr]   : '0;
    assign out_inst  = (count != '0) ? inst_mem[rd_ptr] : '0;

    assign drop_after  = drop_cnt - CW'(resp_drop);
    assign infl_after  = inflight - CW'(resp_live);
    assign redirect_pc = {jump_addr[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (jump) begin
            // Live requests still in memory become stale and are discarded on return.
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
            drop_cnt <= drop_after + infl_after;
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= infl_after + CW'(fire);
            drop_cnt <= drop_after;
            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            inst_mem[wr_ptr] <= resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with configurable latency, randomized
// traffic and redirects, checked every cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        jump = 1'b0;
    logic [31:0] jump_addr = '0;

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .jump(jump), .jump_addr(jump_addr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_fire   = 0;
    int          mem_lat  = 1;
    mreq_t       mem_q[$];
    ent_t        m_fifo[$];
    logic [31:0] m_live[$];
    int          m_stale = 0;
    logic [31:0] m_fetch_pc = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_ABCD;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and memory bookkeeping, evaluated mid-cycle once inputs are stable.
    always @(negedge clk) begin
        bit          exp_rv, exp_ov, got;
        logic [31:0] a;
        if (!rst) begin
            chk("rst_req_valid", 32'(req_valid), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_pc", out_pc, 32'd0);
            chk("rst_out_inst", out_inst, 32'd0);
            m_fifo.delete();
            m_live.delete();
            m_stale    = 0;
            m_fetch_pc = RESET_PC;
            mem_q.delete();
        end else begin
            exp_rv = !jump && (m_fifo.size() + m_live.size() + m_stale < DEPTH);
            exp_ov = !jump && (m_fifo.size() != 0);
            chk("req_valid", 32'(req_valid), 32'(exp_rv));
            if (exp_rv) chk("req_addr", req_addr, m_fetch_pc);
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                chk("out_pc", out_pc, m_fifo[0].pc);
                chk("out_inst", out_inst, m_fifo[0].inst);
            end
            if (resp_valid) void'(mem_q.pop_front());
            if (req_valid && req_ready) begin
                mem_q.push_back('{addr: req_addr, due: cyc + mem_lat});
                n_fire++;
            end
            got = 1'b0;
            a   = '0;
            if (resp_valid) begin
                if (m_stale > 0) m_stale--;
                else if (m_live.size() > 0) begin
                    a   = m_live.pop_front();
                    got = 1'b1;
                end
            end
            if (jump) begin
                m_fifo.delete();
                m_stale += m_live.size();
                m_live.delete();
                m_fetch_pc = {jump_addr[31:2], 2'b00};
            end else begin
                if (exp_ov && out_ready) void'(m_fifo.pop_front());
                if (got) m_fifo.push_back('{pc: a, inst: mem_word(a)});
                if (exp_rv && req_ready) begin
                    m_live.push_back(m_fetch_pc);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(mem_q[0].addr);
        end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom;
        end
    endtask

    task automatic wait_out(input logic [31:0] exp_pc, input string name);
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            #1;
            if (out_valid) begin
                chk(name, out_pc, exp_pc);
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: out_valid never rose, expected pc %h", name, exp_pc);
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            jump      = 1'b0;
            req_ready = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic run_random(input int cycles, input int p_rr, input int p_or, input int p_j);
        for (int i = 0; i < cycles; i++) begin
            next_cycle();
            if ($urandom_range(0, 999) < 4) begin
                rst        = 1'b0;
                resp_valid = 1'b0;
                jump       = 1'b0;
                next_cycle();
                rst = 1'b1;
            end
            req_ready = ($urandom_range(0, 99) < p_rr);
            out_ready = ($urandom_range(0, 99) < p_or);
            jump      = ($urandom_range(0, 99) < p_j);
            if (jump) begin
                case ($urandom_range(0, 3))
                    0:       jump_addr = RESET_PC + 32'($urandom_range(0, 1023));
                    1:       jump_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    default: jump_addr = $urandom;
                endcase
            end
        end
    endtask

    initial begin
        int  f0;
        bit  found;
        repeat (3) @(posedge clk);

        // Streaming from reset with single-cycle memory.
        #1;
        rst = 1'b1; req_ready = 1'b1; out_ready = 1'b1; mem_lat = 1;
        #1;
        chk("t1_req_valid", 32'(req_valid), 32'd1);
        chk("t1_req_addr", req_addr, 32'h8000_0000);
        wait_out(32'h8000_0000, "t1_first_out_pc");
        for (int i = 0; i < 30; i++) next_cycle();

        run_random(300, 70, 60, 3);

        // Mid-operation reset, then fill with decode stalled.
        next_cycle();
        rst = 1'b0; resp_valid = 1'b0; jump = 1'b0; req_ready = 1'b1; out_ready = 1'b0;
        #1;
        chk("t2_async_req_valid", 32'(req_valid), 32'd0);
        chk("t2_async_out_valid", 32'(out_valid), 32'd0);
        next_cycle();
        rst = 1'b1; mem_lat = 1;
        f0 = n_fire;
        for (int i = 0; i < 12; i++) next_cycle();
        #1;
        chk("t2_full_req_valid", 32'(req_valid), 32'd0);
        chk("t2_fire_count", 32'(n_fire - f0), 32'd4);
        out_ready = 1'b1;
        next_cycle();
        out_ready = 1'b0;
        #1;
        chk("t2_refill_req_valid", 32'(req_valid), 32'd1);
        chk("t2_refill_req_addr", req_addr, 32'h8000_0010);
        chk("t2_head_after_pop", out_pc, 32'h8000_0004);

        run_random(300, 60, 70, 4);

        // Redirect with two requests outstanding on a 3-cycle memory.
        drain();
        mem_lat = 3;
        next_cycle(); req_ready = 1'b1;
        next_cycle();
        next_cycle(); req_ready = 1'b0; jump = 1'b1; jump_addr = 32'h8000_0103;
        next_cycle(); jump = 1'b0; req_ready = 1'b1;
        #1;
        chk("t3_req_valid", 32'(req_valid), 32'd1);
        chk("t3_req_addr", req_addr, 32'h8000_0100);
        wait_out(32'h8000_0100, "t3_first_out_pc");

        // Redirect coinciding with a response and a pending pop.
        drain();
        mem_lat = 2; req_ready = 1'b1; out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            if (resp_valid && m_fifo.size() > 0) begin
                jump = 1'b1; jump_addr = 32'h8000_0400; out_ready = 1'b1;
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL t4_setup: no response arrived with a non-empty queue");
        end
        next_cycle();
        jump = 1'b0;
        #1;
        chk("t4_out_valid_after", 32'(out_valid), 32'd0);
        for (int i = 0; i < 10; i++) next_cycle();

        // Back-to-back redirects: the last target wins.
        drain();
        mem_lat = 1;
        next_cycle(); jump = 1'b1; jump_addr = 32'h8000_0200;
        next_cycle(); jump_addr = 32'h8000_0300;
        next_cycle(); jump = 1'b0; req_ready = 1'b1; out_ready = 1'b1;
        #1;
        chk("t5_req_valid", 32'(req_valid), 32'd1);
        chk("t5_req_addr", req_addr, 32'h8000_0300);
        wait_out(32'h8000_0300, "t5_first_out_pc");

        // Address wrap at the top of the address space.
        drain();
        mem_lat = 1;
        next_cycle(); jump = 1'b1; jump_addr = 32'hFFFF_FFFE; req_ready = 1'b1; out_ready = 1'b1;
        next_cycle(); jump = 1'b0;
        #1;
        chk("t6_req_addr_top", req_addr, 32'hFFFF_FFFC);
        next_cycle();
        #1;
        chk("t6_req_addr_wrap", req_addr, 32'h0000_0000);
        wait_out(32'hFFFF_FFFC, "t6_out_pc_top");
        next_cycle();
        #1;
        chk("t6_out_valid_wrap", 32'(out_valid), 32'd1);
        chk("t6_out_pc_wrap", out_pc, 32'h0000_0000);

        run_random(400, 50, 50, 5);
        run_random(300, 90, 30, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
